// File: rtl/commit_trace_buffer_if.sv
// Retire-event handshake bundle: writeback producer side (wb_*) and trace
// consumer side (trace_*) of the commit trace buffer.
interface commit_trace_buffer_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_pc;
  logic [31:0] wb_nextpc;
  logic [31:0] wb_inst;

  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_nextpc;
  logic [31:0] trace_inst;

  // The buffer itself.
  modport slave (
    input  wb_valid, wb_pc, wb_nextpc, wb_inst, trace_ready,
    output wb_ready, trace_valid, trace_pc, trace_nextpc, trace_inst
  );

  // The environment around it: writeback stage plus trace reporter.
  modport master (
    output wb_valid, wb_pc, wb_nextpc, wb_inst, trace_ready,
    input  wb_ready, trace_valid, trace_pc, trace_nextpc, trace_inst
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// First-word-fall-through retire-event FIFO feeding the commit reporter, with
// PC-chain continuity check, commit counter and no-commit watchdog.
module commit_trace_buffer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096,
  parameter int CW      = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  commit_trace_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CW-1:0]            commit_cnt,
  output logic                     pc_mismatch,
  output logic [31:0]              mismatch_pc,
  output logic                     timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic [31:0] inst;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [OW-1:0]   occ_next;
  logic [IW-1:0]   idle_cnt;
  logic [31:0]     expect_pc;
  logic            armed;
  logic            ready_q;
  logic            trace_valid;
  logic            push;
  logic            pop;

  assign trace_valid = (occupancy != '0);
  assign push        = bus.wb_valid & ready_q;
  assign pop         = trace_valid & bus.trace_ready;
  assign occ_next    = occupancy + OW'(push) - OW'(pop);

  assign head             = mem[rd_ptr];
  assign bus.wb_ready     = ready_q;
  assign bus.trace_valid  = trace_valid;
  assign bus.trace_pc     = trace_valid ? head.pc     : '0;
  assign bus.trace_nextpc = trace_valid ? head.nextpc : '0;
  assign bus.trace_inst   = trace_valid ? head.inst   : '0;

  // NOTE: storage has no reset; occupancy gates every read, so stale words are never observed.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: bus.wb_pc, nextpc: bus.wb_nextpc, inst: bus.wb_inst};
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      ready_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occupancy <= occ_next;
      // Registered from the post-edge count so the producer never sees a path from trace_ready.
      ready_q   <= (occ_next < OW'(DEPTH));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      commit_cnt  <= '0;
      expect_pc   <= '0;
      armed       <= 1'b0;
      pc_mismatch <= 1'b0;
      mismatch_pc <= '0;
    end else if (pop) begin
      commit_cnt <= commit_cnt + CW'(1);
      // Only the first chain break is captured.
      if (armed && (head.pc != expect_pc) && !pc_mismatch) begin
        pc_mismatch <= 1'b1;
        mismatch_pc <= head.pc;
      end
      expect_pc <= head.nextpc;
      armed     <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (push) begin
      idle_cnt <= '0;
    end else begin
      if (idle_cnt != IW'(TIMEOUT)) idle_cnt <= idle_cnt + IW'(1);
      if (idle_cnt == IW'(TIMEOUT - 1)) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: reset, latency, full/back-pressure,
// streaming with pointer wrap, chain check, watchdog, and mid-run reset.
module tb_commit_trace_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  occupancy;
  logic [63:0] commit_cnt;
  logic        pc_mismatch;
  logic [31:0] mismatch_pc;
  logic        timeout;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  commit_trace_buffer_if bus ();

  commit_trace_buffer #(.DEPTH(4), .TIMEOUT(16), .CW(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .occupancy   (occupancy),
    .commit_cnt  (commit_cnt),
    .pc_mismatch (pc_mismatch),
    .mismatch_pc (mismatch_pc),
    .timeout     (timeout)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] npc,
                       input logic [31:0] inst);
    bus.wb_valid  = v;
    bus.wb_pc     = pc;
    bus.wb_nextpc = npc;
    bus.wb_inst   = inst;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.trace_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.trace_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    tick();
    tick();
    tests++; if (bus.wb_ready !== 1'b0) begin failed++; $display("FAIL rst_wb_ready: got %b, expected 0", bus.wb_ready); end
    tests++; if (bus.trace_valid !== 1'b0) begin failed++; $display("FAIL rst_trace_valid: got %b, expected 0", bus.trace_valid); end
    tests++; if (occupancy !== 3'd0) begin failed++; $display("FAIL rst_occupancy: got %0d, expected 0", occupancy); end
    tests++; if (commit_cnt !== 64'd0) begin failed++; $display("FAIL rst_commit_cnt: got %0d, expected 0", commit_cnt); end
    tests++; if (bus.trace_pc !== 32'h0) begin failed++; $display("FAIL rst_trace_pc: got %h, expected 0", bus.trace_pc); end
    tests++; if (pc_mismatch !== 1'b0 || timeout !== 1'b0) begin failed++; $display("FAIL rst_flags: got %b%b, expected 00", pc_mismatch, timeout); end
    reset = 1'b0;
    tick();
    tests++; if (bus.wb_ready !== 1'b1) begin failed++; $display("FAIL rst_release_ready: got %b, expected 1", bus.wb_ready); end
  endtask

  task automatic test_single();
    do_reset();
    bus.trace_ready = 1'b1;
    drive(1'b1, 32'h8000_0000, 32'h8000_0004, 32'h0000_0413);
    tests++; if (bus.trace_valid !== 1'b0) begin failed++; $display("FAIL single_no_bypass: got %b, expected 0", bus.trace_valid); end
    tick();
    drive(1'b0, '0, '0, '0);
    tests++; if (bus.trace_valid !== 1'b1) begin failed++; $display("FAIL single_valid: got %b, expected 1", bus.trace_valid); end
    tests++; if (bus.trace_pc !== 32'h8000_0000) begin failed++; $display("FAIL single_pc: got %h, expected 80000000", bus.trace_pc); end
    tests++; if (bus.trace_nextpc !== 32'h8000_0004) begin failed++; $display("FAIL single_nextpc: got %h, expected 80000004", bus.trace_nextpc); end
    tests++; if (bus.trace_inst !== 32'h0000_0413) begin failed++; $display("FAIL single_inst: got %h, expected 00000413", bus.trace_inst); end
    tests++; if (commit_cnt !== 64'd0) begin failed++; $display("FAIL single_cnt_pre: got %0d, expected 0", commit_cnt); end
    tick();
    tests++; if (commit_cnt !== 64'd1) begin failed++; $display("FAIL single_cnt: got %0d, expected 1", commit_cnt); end
    tests++; if (bus.trace_valid !== 1'b0 || bus.trace_pc !== 32'h0) begin failed++; $display("FAIL single_empty: got valid=%b pc=%h, expected 0/0", bus.trace_valid, bus.trace_pc); end
    tests++; if (pc_mismatch !== 1'b0) begin failed++; $display("FAIL single_mismatch: got %b, expected 0", pc_mismatch); end
  endtask

  task automatic test_full();
    logic accepted;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h8000_0000 + 4 * i, 32'h8000_0004 + 4 * i, i);
      tests++; if (bus.wb_ready !== 1'b1) begin failed++; $display("FAIL full_ready_%0d: got %b, expected 1", i, bus.wb_ready); end
      tick();
    end
    drive(1'b1, 32'h8000_0010, 32'h8000_0014, 32'd4);
    tests++; if (bus.wb_ready !== 1'b0) begin failed++; $display("FAIL full_ready_drop: got %b, expected 0", bus.wb_ready); end
    tests++; if (occupancy !== 3'd4) begin failed++; $display("FAIL full_occ: got %0d, expected 4", occupancy); end
    tick();
    tests++; if (occupancy !== 3'd4) begin failed++; $display("FAIL full_hold_occ: got %0d, expected 4", occupancy); end
    tests++; if (bus.trace_pc !== 32'h8000_0000) begin failed++; $display("FAIL full_hold_pc: got %h, expected 80000000", bus.trace_pc); end
    bus.trace_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tests++; if (bus.trace_pc !== 32'h8000_0000 + 4 * j) begin failed++; $display("FAIL full_drain_pc_%0d: got %h, expected %h", j, bus.trace_pc, 32'h8000_0000 + 4 * j); end
      accepted = bus.wb_valid & bus.wb_ready;
      tick();
      if (accepted) bus.wb_valid = 1'b0;
      if (j == 0) begin
        tests++; if (bus.wb_ready !== 1'b1) begin failed++; $display("FAIL full_ready_rise: got %b, expected 1", bus.wb_ready); end
        tests++; if (occupancy !== 3'd3) begin failed++; $display("FAIL full_occ_after_pop: got %0d, expected 3", occupancy); end
      end
    end
    tests++; if (bus.trace_valid !== 1'b0) begin failed++; $display("FAIL full_drained: got %b, expected 0", bus.trace_valid); end
    tests++; if (commit_cnt !== 64'd5) begin failed++; $display("FAIL full_cnt: got %0d, expected 5", commit_cnt); end
    tests++; if (pc_mismatch !== 1'b0) begin failed++; $display("FAIL full_mismatch: got %b, expected 0", pc_mismatch); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 32'h8000_0000, 32'h8000_0004, 32'h13);
    tick();
    drive(1'b1, 32'h8000_0004, 32'h8000_0008, 32'h13);
    tick();
    bus.trace_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h8000_0008 + 4 * k, 32'h8000_000C + 4 * k, 32'h13);
      tests++; if (bus.trace_pc !== 32'h8000_0000 + 4 * k) begin failed++; $display("FAIL b2b_pc_%0d: got %h, expected %h", k, bus.trace_pc, 32'h8000_0000 + 4 * k); end
      tick();
      tests++; if (occupancy !== 3'd2) begin failed++; $display("FAIL b2b_occ_%0d: got %0d, expected 2", k, occupancy); end
    end
    drive(1'b0, '0, '0, '0);
    bus.trace_ready = 1'b0;
    tests++; if (commit_cnt !== 64'd10) begin failed++; $display("FAIL b2b_cnt: got %0d, expected 10", commit_cnt); end
    tests++; if (bus.trace_pc !== 32'h8000_0028) begin failed++; $display("FAIL b2b_head_after_wrap: got %h, expected 80000028", bus.trace_pc); end
    tests++; if (pc_mismatch !== 1'b0) begin failed++; $display("FAIL b2b_mismatch: got %b, expected 0", pc_mismatch); end
  endtask

  task automatic test_chain();
    do_reset();
    drive(1'b1, 32'h8000_0000, 32'h8000_0004, 32'h13);
    tick();
    drive(1'b1, 32'h8000_0010, 32'h8000_0014, 32'h13);
    tick();
    drive(1'b1, 32'h8000_0020, 32'h8000_0024, 32'h13);
    tick();
    drive(1'b0, '0, '0, '0);
    bus.trace_ready = 1'b1;
    tick();
    tests++; if (pc_mismatch !== 1'b0) begin failed++; $display("FAIL chain_first_pop: got %b, expected 0", pc_mismatch); end
    tick();
    tests++; if (pc_mismatch !== 1'b1) begin failed++; $display("FAIL chain_break: got %b, expected 1", pc_mismatch); end
    tests++; if (mismatch_pc !== 32'h8000_0010) begin failed++; $display("FAIL chain_pc: got %h, expected 80000010", mismatch_pc); end
    tick();
    tests++; if (mismatch_pc !== 32'h8000_0010 || pc_mismatch !== 1'b1) begin failed++; $display("FAIL chain_first_only: got %b/%h, expected 1/80000010", pc_mismatch, mismatch_pc); end
    tests++; if (commit_cnt !== 64'd3) begin failed++; $display("FAIL chain_cnt: got %0d, expected 3", commit_cnt); end
  endtask

  task automatic test_timeout();
    bus.trace_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 15; e++) tick();
    tests++; if (timeout !== 1'b0) begin failed++; $display("FAIL wd_early: got %b after 15 edges, expected 0", timeout); end
    tick();
    tests++; if (timeout !== 1'b1) begin failed++; $display("FAIL wd_expire: got %b after 16 edges, expected 1", timeout); end
    tick();
    tests++; if (timeout !== 1'b1) begin failed++; $display("FAIL wd_sticky: got %b, expected 1", timeout); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 15; e++) tick();
    drive(1'b1, 32'h8000_0100, 32'h8000_0104, 32'h13);
    tick();
    drive(1'b0, '0, '0, '0);
    tests++; if (timeout !== 1'b0) begin failed++; $display("FAIL wd_push_wins: got %b, expected 0", timeout); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 32'h8000_0000, 32'h8000_0004, 32'h13);
    tick();
    drive(1'b1, 32'h8000_0040, 32'h8000_0044, 32'h13);
    tick();
    bus.trace_ready = 1'b1;
    drive(1'b1, 32'h8000_0044, 32'h8000_0048, 32'h13);
    tick();
    drive(1'b1, 32'h8000_0048, 32'h8000_004C, 32'h13);
    tick();
    bus.trace_ready = 1'b0;
    drive(1'b1, 32'h8000_004C, 32'h8000_0050, 32'h13);
    tick();
    drive(1'b0, '0, '0, '0);
    tests++; if (occupancy !== 3'd3) begin failed++; $display("FAIL mid_pre_occ: got %0d, expected 3", occupancy); end
    tests++; if (pc_mismatch !== 1'b1 || commit_cnt !== 64'd2) begin failed++; $display("FAIL mid_pre_state: got %b/%0d, expected 1/2", pc_mismatch, commit_cnt); end
    reset = 1'b1;
    bus.trace_ready = 1'b1;
    tick();
    tests++; if (occupancy !== 3'd0 || bus.trace_valid !== 1'b0) begin failed++; $display("FAIL mid_flush: got occ=%0d valid=%b, expected 0/0", occupancy, bus.trace_valid); end
    tests++; if (commit_cnt !== 64'd0) begin failed++; $display("FAIL mid_cnt: got %0d, expected 0", commit_cnt); end
    tests++; if (pc_mismatch !== 1'b0 || mismatch_pc !== 32'h0) begin failed++; $display("FAIL mid_mismatch: got %b/%h, expected 0/0", pc_mismatch, mismatch_pc); end
    tests++; if (bus.wb_ready !== 1'b0) begin failed++; $display("FAIL mid_ready_low: got %b, expected 0", bus.wb_ready); end
    reset = 1'b0;
    tick();
    tests++; if (bus.wb_ready !== 1'b1) begin failed++; $display("FAIL mid_ready_high: got %b, expected 1", bus.wb_ready); end
    tests++; if (commit_cnt !== 64'd0 || bus.trace_valid !== 1'b0) begin failed++; $display("FAIL mid_after: got cnt=%0d valid=%b, expected 0/0", commit_cnt, bus.trace_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation exceeded 200000 time units");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_chain();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
Sits directly upstream of the DPI commit reporter. Captures retire events (pc, nextpc, inst) from the writeback stage into a small first-word-fall-through FIFO and presents them one per cycle on a valid/ready trace port. Adds simulation-side integrity checks:
- PC-chain continuity (each retired pc must equal the previous retired nextpc).
- Commit counter.
- No-commit watchdog.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
TIMEOUT, 4096, cycles without a push before the watchdog flag sets; >= 2
CW, 64, width of the commit counter

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
wb_valid  in  1  writeback stage presents a retired instruction
wb_ready  out  1  buffer can accept an entry this cycle
wb_pc  in  32  pc of retired instruction
wb_nextpc  in  32  architectural next pc of retired instruction
wb_inst  in  32  instruction word
trace_valid  out  1  head entry valid; drives the reporter's valid input
trace_ready  in  1  consumer accepts the head entry; tied 1 in normal simulation
trace_pc  out  32  head entry pc
trace_nextpc  out  32  head entry nextpc
trace_inst  out  32  head entry instruction
occupancy  out  $clog2(DEPTH)+1  current entry count
commit_cnt  out  CW  number of entries popped since reset
pc_mismatch  out  1  sticky: chain break detected
mismatch_pc  out  32  trace_pc of the first chain-breaking entry
timeout  out  1  sticky: watchdog expired

Behaviour:
Reset (reset=1 at a clock edge):
- Clears pointers and occupancy, commit_cnt, pc_mismatch, mismatch_pc, timeout, the idle counter and the chain-armed flag.
- wb_ready resets to 0 and becomes 1 on the first edge with reset=0.
- trace_valid=0 and trace_pc/nextpc/inst=0 while empty.
- Reset mid-operation discards all buffered entries; no pop is counted on a reset edge.

Handshake:
- push = wb_valid & wb_ready.
- pop = trace_valid & trace_ready.
- wb_ready is a register: wb_ready = (occupancy_next < DEPTH). It never depends combinationally on trace_ready or wb_valid.
- trace_valid = (occupancy != 0).
- trace_* show the head entry combinationally from storage. They are 0 when empty and hold stable while trace_valid=1 and trace_ready=0.

Latency: an entry pushed at edge N is visible on trace_* after edge N. There is no same-cycle bypass when empty.

Occupancy and pointers:
- occupancy_next = occupancy + push - pop. Simultaneous push and pop leaves occupancy unchanged.
- When full, wb_ready=0, so push is impossible. A pop at full raises wb_ready on the next cycle.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Pop when empty is impossible because trace_valid=0.

Counter: commit_cnt increments by 1 on each pop and wraps modulo 2^CW.

Chain check:
- Register expect_pc and an armed flag, both 0 at reset.
- On each pop: if armed and trace_pc != expect_pc, and pc_mismatch is 0, then set pc_mismatch=1 and mismatch_pc=trace_pc.
- Every pop then loads expect_pc <= trace_nextpc and sets armed=1.
- The first pop after reset is never flagged.
- Later mismatches leave pc_mismatch and mismatch_pc unchanged (first-error capture).

Watchdog:
- The idle counter resets to 0 on any push; otherwise it increments, saturating at TIMEOUT.
- When idle == TIMEOUT-1 and there is no push, timeout is set on that edge. It is sticky until reset.
- A push on the edge that would expire the watchdog wins: no timeout.

Payload: stored unmodified (32-bit each); no arithmetic on pc values.

Test Plan:
- Reset release, then single push pc=0x80000000 nextpc=0x80000004 inst=0x00000413 with trace_ready=1 -> trace_valid=1 exactly one cycle later with those values; commit_cnt=1 after the pop; pc_mismatch=0.
- trace_ready=0; push 5 sequential entries with DEPTH=4 -> wb_ready drops to 0 after the 4th push and the 5th is held by the producer; occupancy=4; raise trace_ready -> entries drain in order pc 0x80000000..0x8000000C, wb_ready=1 one cycle after the first pop, 5th entry follows.
- Simultaneous push and pop at occupancy=2 for 10 cycles -> occupancy stays 2; pointers wrap past index 3 without reordering; commit_cnt=10.
- Pop pc=0x80000000 nextpc=0x80000004, then pc=0x80000010, then pc=0x80000020 -> pc_mismatch=1, mismatch_pc=0x80000010 (second break not recorded).
- TIMEOUT=16, no pushes after reset -> timeout=1 after the 16th edge; repeat with a push on the 16th edge -> timeout stays 0.
- Assert reset while occupancy=3 and pc_mismatch=1 -> next cycle occupancy=0, trace_valid=0, commit_cnt=0, pc_mismatch=0, wb_ready=0, then wb_ready=1 one cycle after reset drops.
